// File: rtl/mem_access_sched_pkg.sv
// Shared definitions for the single-port memory access scheduler:
// FSM encodings, requester IDs and default widths.
package mem_access_sched_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 8;
    localparam int LEN_W_DEF  = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_BURST = 2'd1,
        RD_BURST = 2'd2,
        RD_DRAIN = 2'd3
    } sched_state_e;

    typedef enum logic {
        REQ_WR = 1'b0,
        REQ_RD = 1'b1
    } req_id_e;

endpackage

// File: rtl/mem_access_sched_rr_pick.sv
// Combinational round-robin choice between the write and read requesters.
// On contention the requester not served last wins.
module mem_rr_pick
    import mem_access_sched_pkg::*;
(
    input  logic    wr_req,
    input  logic    rd_req,
    input  req_id_e last_served,
    output logic    pick_valid,
    output req_id_e pick_id
);

    always_comb begin
        pick_valid = wr_req | rd_req;
        pick_id    = REQ_WR;
        if (wr_req && rd_req) begin
            pick_id = (last_served == REQ_WR) ? REQ_RD : REQ_WR;
        end else if (rd_req) begin
            pick_id = REQ_RD;
        end
    end

endmodule

// File: rtl/mem_access_sched.sv
// Burst-granular round-robin scheduler for a single-port word memory
// shared by a write path and a read-out path.
module mem_access_sched
    import mem_access_sched_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_base,
    input  logic [LEN_W-1:0]  wr_len,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_grant,
    output logic              wr_ready,
    output logic              wr_done,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_base,
    input  logic [LEN_W-1:0]  rd_len,
    output logic              rd_grant,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              rd_done,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    sched_state_e      state_q;
    req_id_e           last_q;
    logic [ADDR_W-1:0] base_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  cnt_q;
    logic              wr_grant_q;
    logic              rd_grant_q;
    logic              wr_done_q;
    logic              rd_done_q;
    logic              rd_valid_q;
    logic [DATA_W-1:0] rd_data_q;

    logic              pick_valid;
    req_id_e           pick_id;
    logic              wr_acc;
    logic              rd_acc;
    logic              last_beat;
    logic              len_zero;
    logic [ADDR_W-1:0] acc_addr;

    mem_rr_pick u_pick (
        .wr_req      (wr_req),
        .rd_req      (rd_req),
        .last_served (last_q),
        .pick_valid  (pick_valid),
        .pick_id     (pick_id)
    );

    // Address wraps modulo the memory depth.
    assign acc_addr  = base_q + ADDR_W'(cnt_q);
    assign len_zero  = (len_q == '0);
    assign last_beat = (cnt_q == len_q - LEN_W'(1));

    assign wr_ready  = (state_q == WR_BURST) && (cnt_q < len_q);
    assign wr_acc    = wr_ready && wr_valid;
    assign rd_acc    = (state_q == RD_BURST) && !len_zero;

    assign mem_en    = wr_acc | rd_acc;
    assign mem_we    = wr_acc;
    assign mem_addr  = mem_en ? acc_addr : '0;
    assign mem_wdata = wr_acc ? wr_data : '0;

    assign wr_grant  = wr_grant_q;
    assign rd_grant  = rd_grant_q;
    assign wr_done   = wr_done_q;
    assign rd_done   = rd_done_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            last_q     <= REQ_RD;
            base_q     <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            wr_grant_q <= 1'b0;
            rd_grant_q <= 1'b0;
            wr_done_q  <= 1'b0;
            rd_done_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            wr_grant_q <= 1'b0;
            rd_grant_q <= 1'b0;
            wr_done_q  <= 1'b0;
            rd_done_q  <= 1'b0;
            rd_valid_q <= rd_acc;
            if (rd_acc) begin
                rd_data_q <= mem_rdata;
            end
            unique case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        cnt_q  <= '0;
                        last_q <= pick_id;
                        if (pick_id == REQ_WR) begin
                            base_q     <= wr_base;
                            len_q      <= wr_len;
                            wr_grant_q <= 1'b1;
                            state_q    <= WR_BURST;
                        end else begin
                            base_q     <= rd_base;
                            len_q      <= rd_len;
                            rd_grant_q <= 1'b1;
                            state_q    <= RD_BURST;
                        end
                    end
                end
                WR_BURST: begin
                    if (len_zero) begin
                        wr_done_q <= 1'b1;
                        state_q   <= IDLE;
                    end else if (wr_acc) begin
                        cnt_q <= cnt_q + LEN_W'(1);
                        if (last_beat) begin
                            wr_done_q <= 1'b1;
                            state_q   <= IDLE;
                        end
                    end
                end
                RD_BURST: begin
                    if (len_zero) begin
                        rd_done_q <= 1'b1;
                        state_q   <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + LEN_W'(1);
                        // Done lines up with the final return in RD_DRAIN.
                        if (last_beat) begin
                            rd_done_q <= 1'b1;
                            state_q   <= RD_DRAIN;
                        end
                    end
                end
                RD_DRAIN: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_sched.sv
// Self-checking bench for mem_access_sched: table of bursts plus
// hand sequences for contention, mid-burst reset and zero length.
module tb_mem_access_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_req, wr_valid, rd_req;
    logic [7:0]  wr_base, wr_len, rd_base, rd_len;
    logic [31:0] wr_data;
    logic        wr_grant, wr_ready, wr_done;
    logic        rd_grant, rd_valid, rd_done;
    logic [31:0] rd_data;
    logic        mem_en, mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    int cmp_n = 0;
    int err_n = 0;

    typedef struct packed {
        logic        we;
        logic [7:0]  addr;
        logic [31:0] data;
    } acc_t;

    acc_t        exp_acc[$];
    logic [31:0] exp_rd[$];
    logic [31:0] sb_mem [256];
    logic [31:0] mem_m  [256];

    bit         mon_en = 1'b0;
    bit         issue_prev = 1'b0;
    bit         en_prev = 1'b0;
    logic [7:0] last_addr = 8'h00;

    logic [79:0] all_o;
    assign all_o = {wr_grant, wr_ready, wr_done, rd_grant, rd_data,
                    rd_valid, rd_done, mem_en, mem_we, mem_addr, mem_wdata};

    mem_access_sched dut (
        .clk       (clk),
        .reset     (reset),
        .wr_req    (wr_req),
        .wr_base   (wr_base),
        .wr_len    (wr_len),
        .wr_data   (wr_data),
        .wr_valid  (wr_valid),
        .wr_grant  (wr_grant),
        .wr_ready  (wr_ready),
        .wr_done   (wr_done),
        .rd_req    (rd_req),
        .rd_base   (rd_base),
        .rd_len    (rd_len),
        .rd_grant  (rd_grant),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .rd_done   (rd_done),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en && mem_we) mem_m[mem_addr] <= mem_wdata;
    end
    assign mem_rdata = mem_m[mem_addr];

    task automatic chk(input string nm, input logic [95:0] act,
                       input logic [95:0] exp);
        cmp_n++;
        if (act !== exp) begin
            err_n++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        acc_t a;
        #2;
        if (mon_en) begin
            if (mem_en) begin
                if (exp_acc.size() == 0) begin
                    cmp_n++;
                    err_n++;
                    $display("FAIL unexpected_access: got we=%0b addr=%0h expected none",
                             mem_we, mem_addr);
                end else begin
                    a = exp_acc.pop_front();
                    chk("acc_we", mem_we, a.we);
                    chk("acc_addr", mem_addr, a.addr);
                    if (a.we) chk("acc_wdata", mem_wdata, a.data);
                end
                last_addr = mem_addr;
            end
            if (rd_valid || issue_prev) chk("rd_valid_timing", rd_valid, issue_prev);
            if (rd_valid) begin
                if (exp_rd.size() == 0) begin
                    cmp_n++;
                    err_n++;
                    $display("FAIL unexpected_rd_valid: got data=%0h expected none", rd_data);
                end else begin
                    chk("rd_data", rd_data, exp_rd.pop_front());
                end
            end
            if (wr_grant || rd_grant) chk("turnaround_gap", en_prev, 0);
        end
        issue_prev = mem_en && !mem_we && reset;
        en_prev    = mem_en;
    end

    task automatic wait_grant(input bit rd, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (rd ? rd_grant : wr_grant) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            cmp_n++;
            err_n++;
            $display("FAIL grant_timeout: got none expected %s grant", rd ? "rd" : "wr");
        end
    endtask

    task automatic wr_phase(input logic [7:0] base, input logic [7:0] len,
                            input logic [31:0] d0, input bit stall, input bit drop);
        int i = 0;
        int t = 0;
        bit v;
        while (i < int'(len)) begin
            @(posedge clk); #1;
            if (drop) wr_req = 1'b0;
            v = stall ? (t % 2 == 0) : 1'b1;
            t++;
            wr_valid = v;
            wr_data  = d0 + 32'(i);
            if (v) begin
                exp_acc.push_back('{we: 1'b1, addr: base + 8'(i), data: d0 + 32'(i)});
                sb_mem[base + 8'(i)] = d0 + 32'(i);
            end
            @(negedge clk);
            chk("wr_ready", wr_ready, 1);
            chk("wr_done_early", wr_done, 0);
            if (t == 1) chk("wr_grant_pulse", wr_grant, 0);
            if (v) i++;
        end
        @(posedge clk); #1;
        if (drop) wr_req = 1'b0;
        wr_valid = 1'b0;
        wr_data  = '0;
        @(negedge clk);
        chk("wr_done", wr_done, 1);
        chk("wr_ready_end", wr_ready, 0);
    endtask

    task automatic rd_phase(input logic [7:0] base, input logic [7:0] len, input bit drop);
        int n;
        for (int i = 0; i < int'(len); i++) begin
            exp_acc.push_back('{we: 1'b0, addr: base + 8'(i), data: 32'h0});
            exp_rd.push_back(sb_mem[base + 8'(i)]);
        end
        n = (len == 0) ? 1 : int'(len);
        @(posedge clk); #1;
        if (drop) rd_req = 1'b0;
        repeat (n - 1) begin
            @(negedge clk);
            chk("rd_done_early", rd_done, 0);
        end
        @(negedge clk);
        chk("rd_done", rd_done, 1);
        chk("rd_valid_at_done", rd_valid, len != 0);
    endtask

    typedef struct {
        bit          is_wr;
        logic [7:0]  base;
        logic [7:0]  len;
        logic [31:0] d0;
        bit          stall;
        logic [7:0]  exp_last;
    } vec_t;

    vec_t tbl[6];

    initial begin
        bit ok;
        bit first_wr;
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        bit is_wr_g;
        for (int i = 0; i < 256; i++) begin
            mem_m[i]  = 32'hDEAD0000 + 32'(i);
            sb_mem[i] = 32'hDEAD0000 + 32'(i);
        end
        tbl[0] = '{1'b1, 8'h10, 8'd4, 32'hA0, 1'b0, 8'h13};
        tbl[1] = '{1'b0, 8'h10, 8'd4, 32'h0,  1'b0, 8'h13};
        tbl[2] = '{1'b1, 8'hFE, 8'd3, 32'hB0, 1'b1, 8'h00};
        tbl[3] = '{1'b0, 8'hFE, 8'd3, 32'h0,  1'b0, 8'h00};
        tbl[4] = '{1'b1, 8'h20, 8'd0, 32'hE0, 1'b0, 8'h00};
        tbl[5] = '{1'b0, 8'h10, 8'd0, 32'h0,  1'b0, 8'h00};

        reset = 1'b0;
        {wr_req, wr_valid, rd_req} = '0;
        {wr_base, wr_len, rd_base, rd_len} = '0;
        wr_data = '0;
        repeat (3) @(posedge clk);
        #1;
        mon_en = 1'b1;
        reset  = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("reset_outputs", all_o, 0);
        end

        for (int n = 0; n < 6; n++) begin
            @(posedge clk); #1;
            if (tbl[n].is_wr) begin
                wr_req = 1'b1; wr_base = tbl[n].base; wr_len = tbl[n].len;
                wait_grant(1'b0, ok);
                if (ok) wr_phase(tbl[n].base, tbl[n].len, tbl[n].d0, tbl[n].stall, 1'b1);
                else wr_req = 1'b0;
            end else begin
                rd_req = 1'b1; rd_base = tbl[n].base; rd_len = tbl[n].len;
                wait_grant(1'b1, ok);
                if (ok) rd_phase(tbl[n].base, tbl[n].len, 1'b1);
                else rd_req = 1'b0;
            end
            @(negedge clk);
            chk("queues_empty", exp_acc.size() + exp_rd.size(), 0);
            if (tbl[n].len != 0) chk("last_addr", last_addr, tbl[n].exp_last);
            repeat (2) @(negedge clk);
        end

        // Contention: both held, expect W,R,W,R.
        @(posedge clk); #1;
        wr_req = 1'b1; rd_req = 1'b1;
        wr_base = 8'h40; wr_len = 8'd2; rd_base = 8'h40; rd_len = 8'd2;
        for (int g = 0; g < 4; g++) begin
            ok = 1'b0;
            for (int k = 0; k < 30 && !ok; k++) begin
                @(negedge clk);
                if (wr_grant || rd_grant) ok = 1'b1;
            end
            if (!ok) begin
                cmp_n++;
                err_n++;
                $display("FAIL contention_timeout: got none expected grant %0d", g);
                break;
            end
            chk("grant_order_rd", rd_grant, g % 2);
            chk("grant_order_wr", wr_grant, (g % 2) == 0);
            is_wr_g = wr_grant;
            if (g == 3) begin
                wr_req = 1'b0;
                rd_req = 1'b0;
            end
            if (is_wr_g) wr_phase(8'h40, 8'd2, 32'hC0 + 32'(g), 1'b0, 1'b0);
            else rd_phase(8'h40, 8'd2, 1'b0);
        end
        wr_req = 1'b0;
        rd_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("contention_queues", exp_acc.size() + exp_rd.size(), 0);

        // Reset after the 2nd of 4 writes.
        @(posedge clk); #1;
        wr_req = 1'b1; wr_base = 8'h50; wr_len = 8'd4;
        wait_grant(1'b0, ok);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            wr_req = 1'b0; wr_valid = 1'b1; wr_data = 32'hD0 + 32'(i);
            exp_acc.push_back('{we: 1'b1, addr: 8'h50 + 8'(i), data: 32'hD0 + 32'(i)});
            sb_mem[8'h50 + 8'(i)] = 32'hD0 + 32'(i);
            @(negedge clk);
        end
        @(posedge clk); #1;
        reset = 1'b0; wr_valid = 1'b0; wr_data = '0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("midreset_outputs", all_o, 0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("midreset_no_done", wr_done, 0);
        end

        // First contention after reset goes to write; both zero length.
        @(posedge clk); #1;
        wr_req = 1'b1; rd_req = 1'b1; wr_len = 8'd0; rd_len = 8'd0;
        wr_base = 8'h60; rd_base = 8'h60;
        ok = 1'b0;
        for (int k = 0; k < 30 && !ok; k++) begin
            @(negedge clk);
            if (wr_grant || rd_grant) ok = 1'b1;
        end
        chk("post_reset_first_wr", {wr_grant, rd_grant}, 2'b10);
        if (wr_grant) begin
            wr_phase(8'h60, 8'd0, 32'h0, 1'b0, 1'b1);
            wait_grant(1'b1, ok);
            if (ok) rd_phase(8'h60, 8'd0, 1'b1);
        end
        wr_req = 1'b0;
        rd_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("final_queues", exp_acc.size() + exp_rd.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
        $finish;
    end

endmodule

// File: doc/mem_access_sched.md
Name: mem_access_sched

Overview:
- Sequences the single-port word memory between two requesters:
  - the UART-fed write path, which writes a received word burst;
  - a read-out path, which reads a word burst back for transmit or processing.
- Arbitrates round-robin at burst granularity. Once granted, a burst runs to completion without interruption.
- Generates every memory enable, write-enable and address; the requesters never touch the memory directly.

Parameters:
- DATA_W, 32: memory word width.
- ADDR_W, 8: memory address width; depth is 2^ADDR_W words.
- LEN_W, 8: burst length counter width.

Ports:
- clk  input  1  single clock, all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- wr_req  input  1  write burst request, level.
- wr_base  input  ADDR_W  write start address, sampled at grant.
- wr_len  input  LEN_W  words in write burst, sampled at grant.
- wr_data  input  DATA_W  write word.
- wr_valid  input  1  wr_data valid.
- wr_grant  output  1  one-cycle pulse: write burst accepted.
- wr_ready  output  1  scheduler accepts wr_data this cycle.
- wr_done  output  1  one-cycle pulse: write burst finished.
- rd_req  input  1  read burst request, level.
- rd_base  input  ADDR_W  read start address, sampled at grant.
- rd_len  input  LEN_W  words in read burst, sampled at grant.
- rd_grant  output  1  one-cycle pulse: read burst accepted.
- rd_data  output  DATA_W  read word.
- rd_valid  output  1  rd_data valid.
- rd_done  output  1  one-cycle pulse, coincident with last rd_valid.
- mem_en  output  1  memory access enable.
- mem_we  output  1  1 = write, 0 = read.
- mem_addr  output  ADDR_W  memory address.
- mem_wdata  output  DATA_W  memory write data.
- mem_rdata  input  DATA_W  memory read data, valid 1 cycle after a read access.

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE, last_served=RD, counters=0.
  - All outputs 0, including rd_data and mem_wdata.
  - Applies mid-burst as well: the burst is abandoned and no done pulse is issued.
  - An in-flight read return is discarded.
- States: IDLE, WR_BURST, RD_BURST, RD_DRAIN.
- IDLE:
  - Requests are sampled only in IDLE.
  - Only wr_req set -> WR_BURST. Only rd_req set -> RD_BURST.
  - Both set -> grant the requester that is not last_served. The first contention after reset goes to write.
  - On the transition: pulse the grant, latch base/len, cnt=0, update last_served.
- Zero-length burst (len==0):
  - Grant pulse, then the done pulse in the following cycle, then IDLE.
  - No mem_en is asserted.
  - For reads, rd_done has no rd_valid.
- WR_BURST:
  - wr_ready=1 while cnt<len.
  - On each cycle with wr_valid: mem_en=1, mem_we=1, mem_addr=base+cnt (mod 2^ADDR_W), mem_wdata=wr_data, cnt++.
  - mem signals are combinational from this cycle's inputs.
  - Cycles without wr_valid: no access; stalls are unbounded.
  - After the access with cnt==len-1: next cycle wr_ready=0, wr_done pulses, state=IDLE.
- RD_BURST:
  - Every cycle: mem_en=1, mem_we=0, mem_addr=base+cnt, cnt++. The read path cannot stall.
  - After issuing cnt==len-1 -> RD_DRAIN.
- Read return:
  - rd_valid is a register of (mem_en & ~mem_we); rd_data is registered mem_rdata.
  - Each rd_valid appears exactly 1 cycle after its issue.
- RD_DRAIN:
  - One cycle, no access.
  - The last rd_valid occurs here with rd_done=1; then IDLE.
- Bus-turnaround rule:
  - A done pulse coincides with the IDLE cycle, so a new grant occurs no earlier than the cycle after done.
  - There is therefore at least one access-free cycle between bursts.
- Requester rules:
  - Holding req through done does not re-grant in that same cycle.
  - A requester still asserting req in IDLE competes normally.
- Address arithmetic:
  - base+cnt truncates to ADDR_W bits; wrap from 2^ADDR_W-1 to 0 is legal.
  - Lengths above depth rewrite or reread wrapped addresses.
- Requester-side violations:
  - wr_valid outside WR_BURST is ignored.
  - wr_data is never written without wr_ready.

Decomposition:
- The shared header (alongside the existing memory header) holds:
  - state encodings: IDLE=2'd0, WR_BURST=2'd1, RD_BURST=2'd2, RD_DRAIN=2'd3;
  - requester IDs: REQ_WR=1'b0, REQ_RD=1'b1;
  - default width constants.
- One natural sub-module: mem_rr_pick, a combinational round-robin choice.
  - Inputs: wr_req, rd_req, last_served.
  - Outputs: pick_valid, pick_id.
- The FSM, counter and read-return pipeline stay in mem_access_sched.

Test Plan:
- Reset behaviour: reset low 3 cycles, then high with no requests -> all outputs 0; mem_en stays 0 for 10 cycles.
- Write burst: wr_base=8'h10, wr_len=4, wr_valid continuous, data 0xA0..0xA3.
  - Required: wr_grant 1 cycle.
  - Then 4 writes to addresses 0x10..0x13 with matching data.
  - wr_done in the cycle after the last write; scoreboard memory matches.
- Read burst: rd_base=8'h10, rd_len=4 after the write burst.
  - Required: reads at 0x10..0x13 on consecutive cycles.
  - rd_valid on 4 consecutive cycles, each 1 cycle after its issue, data 0xA0..0xA3.
  - rd_done with the 4th rd_valid.
- Contention: wr_req and rd_req both asserted continuously, len=2 each.
  - Required grant order: WR, RD, WR, RD.
  - At least 1 access-free cycle between bursts.
- Stall, wrap and zero length:
  - Write base=8'hFE, len=3, wr_valid toggling 1,0,1,0,1 -> addresses FE, FF, 00 only on valid cycles.
  - rd_len=0 -> rd_grant, then rd_done the next cycle, with no mem_en and no rd_valid.
- Reset mid-burst: assert reset after the 2nd of 4 writes -> next cycle all outputs 0 and no wr_done; a fresh request then grants normally.
